// File: rtl/fmc_adc_mezzanine_lite.sv
// FMC ADC acquisition control: WB CSRs, trigger unit, timetag, multishot FSM; FMC_ADC_TRIG_TAG_EN adds TRIG_TAG at 0x3C.
// Latency: WB ack, sample path and irqs 1 cycle; ext trigger fires 3+EXT_TRIG_DLY cycles after first sampled high.
// Backpressure: none; wb_stall_o tied low and samples are forwarded unconditionally.
module fmc_adc_mezzanine_lite #(
  parameter int G_SHOTS_W = 16
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic [63:0] adc_data_i,
  input  logic        adc_valid_i,
  input  logic        serdes_pll_i,
  input  logic        serdes_synced_i,
  input  logic        ext_trig_i,
  output logic        acq_wr_o,
  output logic [63:0] acq_dat_o,
  output logic        acq_trig_o,
  output logic        trig_irq_o,
  output logic        acq_end_irq_o,
  output logic        acq_cfg_ok_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd1, ST_PRE = 3'd2, ST_WAIT = 3'd3, ST_POST = 3'd4, ST_DECR = 3'd5
  } fsm_t;

  fsm_t                 state, state_nxt;
  logic [31:0]          cnt, cnt_nxt;
  logic [G_SHOTS_W-1:0] shots, shots_left, shots_left_nxt;
  logic [31:0]          pre_samples, post_samples, ext_dly, time_trig, timetag, trig_tag_rd, rd_mux;
  logic [31:0]          thres [4];
  logic [11:0]          trig_en;
  logic [5:0]           idx;
  logic                 wr, start, stop, sw_trig, cfg_ok, time_hit, trig_any, trig_acc, end_pulse;
  logic                 ext_s1, ext_s2, ext_s3, ext_pend, ext_fire;
  logic [31:0]          ext_cnt;
  logic [3:0]           thr_below, thr_above, thr_armed, thr_hit;
  logic                 unused_adr;

  assign idx        = wb_adr_i[7:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign wr         = wb_cyc_i & wb_stb_i & wb_we_i;
  assign start      = wr & (idx == 6'h00) & wb_dat_i[0];
  assign stop       = wr & (idx == 6'h00) & wb_dat_i[1];
  assign sw_trig    = wr & (idx == 6'h03);
  assign cfg_ok     = (shots != '0) && (post_samples != '0);
  assign acq_cfg_ok_o = cfg_ok;
  assign wb_stall_o = 1'b0;

  // Thresholds compared in 17 bits so val-hyst never wraps
  for (genvar c = 0; c < 4; c++) begin : g_thr
    logic signed [16:0] smp, lvl, low;
    assign smp          = $signed({adc_data_i[16*c+15], adc_data_i[16*c +: 16]});
    assign lvl          = $signed({thres[c][15], thres[c][15:0]});
    assign low          = lvl - $signed({thres[c][31], thres[c][31:16]});
    assign thr_below[c] = smp < low;
    assign thr_above[c] = smp > lvl;
  end
  assign thr_hit  = {4{adc_valid_i}} & thr_armed & ~thr_below & thr_above;
  assign time_hit = (timetag == time_trig);
  assign trig_any = (trig_en[0] & ext_fire) | (trig_en[1] & sw_trig) | (trig_en[4] & time_hit) |
                    (|(trig_en[11:8] & thr_hit));

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      shots <= '0; pre_samples <= '0; post_samples <= '0; ext_dly <= '0;
      time_trig <= '0; timetag <= '0; trig_en <= '0;
      for (int i = 0; i < 4; i++) thres[i] <= '0;
    end else begin
      timetag <= timetag + 32'd1;
      if (wr) begin
        case (idx)
          6'h02: trig_en <= wb_dat_i[11:0] & 12'hF13;
          6'h04: shots <= wb_dat_i[G_SHOTS_W-1:0];
          6'h05: pre_samples <= wb_dat_i;
          6'h06: post_samples <= wb_dat_i;
          6'h07: ext_dly <= wb_dat_i;
          6'h0C: time_trig <= wb_dat_i;
          6'h0D: timetag <= wb_dat_i;
          default: ;
        endcase
        if (idx[5:2] == 4'd2) thres[idx[1:0]] <= wb_dat_i;
      end
    end
  end

  // Ext trigger: sync, edge detect, then a one-shot delay that ignores further edges
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      {ext_s1, ext_s2, ext_s3, ext_pend, ext_fire} <= '0;
      ext_cnt   <= '0;
      thr_armed <= '0;
    end else begin
      ext_s1   <= ext_trig_i;
      ext_s2   <= ext_s1;
      ext_s3   <= ext_s2;
      ext_fire <= ext_pend & (ext_cnt == '0);
      if (ext_pend) begin
        if (ext_cnt == '0) ext_pend <= 1'b0;
        else               ext_cnt  <= ext_cnt - 32'd1;
      end else if (ext_s2 & ~ext_s3) begin
        ext_pend <= 1'b1;
        ext_cnt  <= ext_dly;
      end
      if (adc_valid_i) thr_armed <= thr_below | (thr_armed & ~thr_above);
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shots_left_nxt = shots_left;
    trig_acc       = 1'b0;
    end_pulse      = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: if (start && cfg_ok) begin
          shots_left_nxt = shots;
          cnt_nxt        = '0;
          state_nxt      = (pre_samples == '0) ? ST_WAIT : ST_PRE;
        end
        ST_PRE: if (adc_valid_i) begin
          if (cnt + 32'd1 >= pre_samples) begin cnt_nxt = '0; state_nxt = ST_WAIT; end
          else cnt_nxt = cnt + 32'd1;
        end
        ST_WAIT: if (trig_any) begin
          trig_acc  = 1'b1;
          cnt_nxt   = 32'(adc_valid_i);
          state_nxt = (32'(adc_valid_i) >= post_samples) ? ST_DECR : ST_POST;
        end
        ST_POST: if (adc_valid_i) begin
          if (cnt + 32'd1 >= post_samples) begin cnt_nxt = '0; state_nxt = ST_DECR; end
          else cnt_nxt = cnt + 32'd1;
        end
        ST_DECR: begin
          shots_left_nxt = shots_left - G_SHOTS_W'(1);
          cnt_nxt        = '0;
          if (shots_left <= G_SHOTS_W'(1)) begin
            state_nxt = ST_IDLE;
            end_pulse = 1'b1;
          end else begin
            state_nxt = (pre_samples == '0) ? ST_WAIT : ST_PRE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shots_left <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shots_left <= shots_left_nxt;
    end
  end

`ifdef FMC_ADC_TRIG_TAG_EN
  logic [31:0] trig_tag;
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)  trig_tag <= '0;
    else if (trig_acc) trig_tag <= timetag;
  end
  assign trig_tag_rd = trig_tag;
`else
  assign trig_tag_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (idx)
      6'h01: rd_mux = {26'd0, cfg_ok, serdes_synced_i, serdes_pll_i, state};
      6'h02: rd_mux = {20'd0, trig_en};
      6'h04: rd_mux = 32'(shots);
      6'h05: rd_mux = pre_samples;
      6'h06: rd_mux = post_samples;
      6'h07: rd_mux = ext_dly;
      6'h08, 6'h09, 6'h0A, 6'h0B: rd_mux = thres[idx[1:0]];
      6'h0C: rd_mux = time_trig;
      6'h0D: rd_mux = timetag;
      6'h0E: rd_mux = 32'(shots_left);
      6'h0F: rd_mux = trig_tag_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wb_ack_o <= 1'b0; wb_dat_o <= '0;
      acq_wr_o <= 1'b0; acq_dat_o <= '0; acq_trig_o <= 1'b0;
      trig_irq_o <= 1'b0; acq_end_irq_o <= 1'b0;
    end else begin
      wb_ack_o      <= wb_cyc_i & wb_stb_i;
      wb_dat_o      <= (wb_cyc_i & wb_stb_i & ~wb_we_i) ? rd_mux : '0;
      acq_wr_o      <= adc_valid_i & (state == ST_PRE || state == ST_WAIT || state == ST_POST);
      acq_dat_o     <= adc_data_i;
      acq_trig_o    <= trig_acc;
      trig_irq_o    <= trig_acc;
      acq_end_irq_o <= end_pulse;
    end
  end

endmodule

// File: tb/tb_fmc_adc_mezzanine_lite.sv
// Randomized bench for fmc_adc_mezzanine_lite with a behavioural timetag/threshold model and data scoreboard.
`timescale 1ns/1ps
module tb_fmc_adc_mezzanine_lite;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [7:0]  wb_adr = '0;
  logic [31:0] wb_wdat = '0, wb_rdat;
  logic        wb_ack, wb_stall;
  logic [63:0] adc_data = '0, acq_dat, prev_dat = '0;
  logic        adc_valid = 0, pll = 1, synced = 1, ext_trig = 0;
  logic        acq_wr, acq_trig, trig_irq, end_irq, cfg_ok;

  int checks = 0, failures = 0;
  int n_trig = 0, n_end = 0, n_atrig = 0, cc = 0, last_trig_cc = 0;
  int adc_mode = 0, budget = 0, tri_v = 0, tri_dir = 8, exp_thr = 0;
  bit thr_armed = 0;
  logic [31:0] model_tt = '0, d;

  always #4 clk = ~clk;

  fmc_adc_mezzanine_lite dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
    .wb_dat_i(wb_wdat), .wb_dat_o(wb_rdat), .wb_ack_o(wb_ack), .wb_stall_o(wb_stall),
    .adc_data_i(adc_data), .adc_valid_i(adc_valid),
    .serdes_pll_i(pll), .serdes_synced_i(synced), .ext_trig_i(ext_trig),
    .acq_wr_o(acq_wr), .acq_dat_o(acq_dat), .acq_trig_o(acq_trig),
    .trig_irq_o(trig_irq), .acq_end_irq_o(end_irq), .acq_cfg_ok_o(cfg_ok)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Timetag reference: loads on a sampled write to 0x34, otherwise counts every clock
  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_tt <= '0;
    else if (wb_cyc && wb_stb && wb_we && wb_adr[7:2] == 6'h0D) model_tt <= wb_wdat;
    else model_tt <= model_tt + 32'd1;

  always @(posedge clk) begin
    cc       <= cc + 1;
    prev_dat <= adc_data;
  end

  always @(negedge clk) begin
    if (trig_irq) begin n_trig++; last_trig_cc = cc; end
    if (end_irq) n_end++;
    if (acq_trig) n_atrig++;
    if (acq_wr) check("acq_dat", acq_dat, prev_dat);
  end

  // Sample source: quiet, random, triangle on ch1 (with threshold model), or a counted burst
  initial forever begin
    @(negedge clk);
    case (adc_mode)
      1: begin adc_valid = 1'($urandom_range(0, 1)); adc_data = {$urandom, $urandom}; end
      2: begin
        adc_valid = ($urandom_range(0, 3) != 0);
        adc_data  = {$urandom, $urandom};
        if (adc_valid) begin
          adc_data[15:0] = 16'(tri_v);
          if (tri_v < 256 - 64) thr_armed = 1;
          else if (thr_armed && tri_v > 256) begin exp_thr++; thr_armed = 0; end
          tri_v += tri_dir;
          if (tri_v >= 400) tri_dir = -8;
          else if (tri_v <= -400) tri_dir = 8;
        end
      end
      3: begin
        adc_data  = {$urandom, $urandom};
        adc_valid = (budget > 0);
        if (budget > 0) budget--;
      end
      default: adc_valid = 1'b0;
    endcase
  end

  task automatic wb_write(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = a; wb_wdat = v;
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    check("wb_wr_ack", wb_ack, 1);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] v);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = a;
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0;
    check("wb_rd_ack", wb_ack, 1);
    v = wb_rdat;
  endtask

  task automatic burst(input int n);
    budget = n;
    adc_mode = 3;
    for (int i = 0; i < 100 && budget > 0; i++) @(negedge clk);
    check("burst_done", budget, 0);
    repeat (4) @(negedge clk);
    adc_mode = 0;
  endtask

  initial begin
    int t0, e0, k_cc;
    repeat (3) @(negedge clk);
    check("reset_outputs", {wb_ack, acq_wr, acq_trig, trig_irq, end_irq, cfg_ok, wb_stall, wb_rdat, acq_dat}, 0);
    rst_n = 1;
    wb_read(8'h04, d);  check("sta_reset", d, 32'h19);
    wb_write(8'h14, 0); wb_write(8'h18, 1); wb_write(8'h10, 1);
    wb_read(8'h04, d);  check("sta_cfg_ok", d, 32'h39);
    check("cfg_ok_pin", cfg_ok, 1);
    wb_write(8'h08, 32'hFFFF_FFFF);
    wb_read(8'h08, d);  check("trig_en_mask", d, 32'h0F13);
    wb_write(8'h08, 32'h2);
    wb_read(8'h40, d);  check("unmapped_rd", d, 0);
    wb_read(8'h3C, d);  check("trig_tag_init", d, 0);
    wb_write(8'h04, 32'hFFFF_FFFF);
    wb_read(8'h04, d);  check("sta_ro", d, 32'h39);
    wb_write(8'h34, 32'h1234_5678);
    wb_read(8'h34, d);  check("timetag_rd", d, model_tt - 32'd1);

    wb_write(8'h0C, 0); repeat (3) @(negedge clk);
    check("sw_trig_idle", n_trig, 0);
    wb_write(8'h10, 0); wb_write(8'h00, 1);
    wb_read(8'h04, d);  check("start_no_cfg", d, 32'h19);
    wb_write(8'h10, 1);

    // Single shot, software trigger, POST=2 paced by counted samples
    wb_write(8'h18, 2); wb_write(8'h00, 1);
    wb_read(8'h04, d);  check("fsm_wait", d[2:0], 3);
    wb_write(8'h0C, 0);
    wb_read(8'h04, d);  check("fsm_post", d[2:0], 4);
    check("sw_trig_cnt", n_trig, 1);
    burst(2);
    wb_read(8'h04, d);  check("fsm_idle_end", d[2:0], 1);
    check("end_irq_single", n_end, 1);

    // PRE=4: exactly four valid samples needed before WAIT
    wb_write(8'h14, 4); wb_write(8'h00, 1);
    wb_read(8'h04, d);  check("fsm_pre", d[2:0], 2);
    burst(3);
    wb_read(8'h04, d);  check("fsm_pre_3", d[2:0], 2);
    burst(1);
    wb_read(8'h04, d);  check("fsm_pre_done", d[2:0], 3);
    wb_write(8'h00, 2);
    wb_read(8'h04, d);  check("fsm_stop", d[2:0], 1);
    check("stop_no_end", n_end, 1);
    wb_write(8'h14, 0);

    // Multishot: three software triggers 500 ns apart
    adc_mode = 1; t0 = n_trig; e0 = n_end;
    wb_write(8'h10, 3); wb_write(8'h18, 1); wb_write(8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      wb_write(8'h0C, 0); #500;
      if (i == 0) begin wb_read(8'h38, d); check("shots_left_mid", d, 2); end
    end
    check("multi_trig", n_trig - t0, 3);
    check("multi_end", n_end - e0, 1);
    wb_read(8'h04, d);  check("multi_fsm", d[2:0], 1);
    wb_read(8'h38, d);  check("multi_left", d, 0);

    // Ch1 threshold on a triangle with random valid gaps
    adc_mode = 0; t0 = n_trig;
    wb_write(8'h10, 20); wb_write(8'h08, 32'h100); wb_write(8'h20, 32'h0040_0100);
    wb_write(8'h00, 1);
    tri_v = -400; tri_dir = 8; thr_armed = 0; exp_thr = 0;
    adc_mode = 2;
    repeat (900) @(negedge clk);
    adc_mode = 0;
    repeat (10) @(negedge clk);
    check("thr_trig", n_trig - t0, exp_thr);
    wb_read(8'h38, d);  check("thr_left", d, 20 - exp_thr);
    wb_write(8'h00, 2);

    // External trigger with delay 3; second pulse falls in the pending window
    adc_mode = 1; t0 = n_trig;
    wb_write(8'h10, 2); wb_write(8'h1C, 3); wb_write(8'h08, 32'h1); wb_write(8'h00, 1);
    @(negedge clk); #1; k_cc = cc + 1;
    ext_trig = 1; #10 ext_trig = 0; #10 ext_trig = 1; #10 ext_trig = 0;
    repeat (40) @(negedge clk);
    check("ext_trig_cnt", n_trig - t0, 1);
    check("ext_latency", last_trig_cc - k_cc, 3 + 3 + 1);
    wb_read(8'h04, d);  check("ext_fsm_wait", d[2:0], 3);
    wb_write(8'h00, 2);

    // Time trigger at TIMETAG=0xE00, then stop during POST
    t0 = n_trig; e0 = n_end;
    wb_write(8'h10, 1); wb_write(8'h18, 2000); wb_write(8'h08, 32'h10);
    wb_write(8'h30, 32'hE00); wb_write(8'h00, 1); wb_write(8'h34, 0);
    for (int i = 0; i < 5000 && !trig_irq; i++) @(negedge clk);
    check("time_trig_at", model_tt, 32'hE01);
    repeat (100) @(negedge clk);
    check("time_trig_cnt", n_trig - t0, 1);
    wb_read(8'h04, d);  check("time_fsm_post", d[2:0], 4);
`ifdef FMC_ADC_TRIG_TAG_EN
    wb_read(8'h3C, d);  check("trig_tag", d, 32'hE00);
`else
    wb_read(8'h3C, d);  check("trig_tag_off", d, 0);
`endif
    wb_write(8'h00, 2);
    wb_read(8'h04, d);  check("stop_mid_post", d[2:0], 1);
    repeat (50) @(negedge clk);
    check("stop_no_end_irq", n_end - e0, 0);

    // No sample writes while idle
    t0 = 0;
    repeat (50) begin @(negedge clk); if (acq_wr) t0++; end
    check("idle_no_wr", t0, 0);
    check("acq_trig_match", n_atrig, n_trig);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
